call_stack_ctrl: RTL and testbench

CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

---
 rtl/call_stack_ctrl.sv | 120 ++++++++++++
 tb/tb_call_stack_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_ctrl.sv
// Call/return stack controller.
// Tracks nested CALL frames and hands return addresses back to the PC logic.
// Frame k lives at stack address k (k = 1..DEPTH). Address 0 is never written.
// Request semantics: cs_call/cs_ret are single-cycle requests.
// They are sampled only while cs_busy is low, i.e. in IDLE. The decoder must
// hold off new requests while cs_busy is high; anything presented then is dropped.
module call_stack_ctrl #(
    parameter int PC_WIDTH = 5,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_call,
    input  logic                cs_ret,
    input  logic [PC_WIDTH-1:0] cs_pc_in,
    input  logic                cs_flag_clr,
    output logic                cs_stack_push,
    output logic                cs_stack_pop,
    output logic [PC_WIDTH-1:0] cs_stack_pointer,
    output logic [PC_WIDTH-1:0] cs_ret_pc,
    output logic                cs_ret_valid,
    output logic                cs_busy,
    output logic                cs_full,
    output logic                cs_empty,
    output logic                cs_overflow,
    output logic                cs_underflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CALL_PUSH = 2'd1,
        RET_SETUP = 2'd2,
        RET_POP   = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] SP_MAX = PC_WIDTH'(DEPTH);

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] sp, sp_nxt;
    logic                call_ok, ret_ok, ov_set, un_set;

    // Sized to the full pointer range so it can be indexed directly by sp.
    // Only entries 1..DEPTH are ever written.
    logic [PC_WIDTH-1:0] ra [0:(2**PC_WIDTH)-1];

    // Request qualification: only IDLE listens. A call has priority over a ret.
    always_comb begin
        call_ok = (state == IDLE) && cs_call && (sp != SP_MAX);
        ret_ok  = (state == IDLE) && cs_ret && !cs_call && (sp != '0);
        ov_set  = (state == IDLE) && cs_call && (sp == SP_MAX);
        un_set  = (state == IDLE) && cs_ret && !cs_call && (sp == '0);
    end

    // Next-state and next-SP decode.
    always_comb begin
        state_nxt = state;
        sp_nxt    = sp;
        case (state)
            IDLE: begin
                if (call_ok) begin
                    state_nxt = CALL_PUSH;
                    sp_nxt    = sp + PC_WIDTH'(1);
                end else if (ret_ok) begin
                    state_nxt = RET_SETUP;
                end
            end
            CALL_PUSH: state_nxt = IDLE;
            RET_SETUP: state_nxt = RET_POP;
            RET_POP: begin
                state_nxt = IDLE;
                sp_nxt    = sp - PC_WIDTH'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and stack-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sp    <= '0;
        end else begin
            state <= state_nxt;
            sp    <= sp_nxt;
        end
    end

    // Sticky error flags. A set condition in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_overflow  <= 1'b0;
            cs_underflow <= 1'b0;
        end else begin
            if (ov_set)           cs_overflow  <= 1'b1;
            else if (cs_flag_clr) cs_overflow  <= 1'b0;
            if (un_set)           cs_underflow <= 1'b1;
            else if (cs_flag_clr) cs_underflow <= 1'b0;
        end
    end

    // Return-address store. The address wraps modulo 2^PC_WIDTH. No reset is needed.
    always_ff @(posedge clk) begin
        if (call_ok) begin
            ra[sp + PC_WIDTH'(1)] <= cs_pc_in + PC_WIDTH'(1);
        end
    end

    // Moore outputs decoded from state and SP only.
    always_comb begin
        cs_stack_push    = (state == CALL_PUSH);
        cs_stack_pop     = (state == RET_POP);
        cs_ret_valid     = (state == RET_POP);
        cs_busy          = (state != IDLE);
        cs_stack_pointer = sp;
        cs_full          = (sp == SP_MAX);
        cs_empty         = (sp == '0);
        cs_ret_pc        = (state == RET_POP) ? ra[sp] : '0;
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl.
// It applies a directed vector table, hand-written corner sequences, and
// randomized traffic checked against a transaction-level stack model.
module tb_call_stack_ctrl;

    localparam int PW    = 5;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_call = 1'b0, cs_ret = 1'b0, cs_flag_clr = 1'b0;
    logic [PW-1:0] cs_pc_in = '0;
    logic          cs_stack_push, cs_stack_pop, cs_ret_valid, cs_busy;
    logic          cs_full, cs_empty, cs_overflow, cs_underflow;
    logic [PW-1:0] cs_stack_pointer, cs_ret_pc;

    always #5 clk = ~clk;

    call_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cs_call(cs_call), .cs_ret(cs_ret),
        .cs_pc_in(cs_pc_in), .cs_flag_clr(cs_flag_clr),
        .cs_stack_push(cs_stack_push), .cs_stack_pop(cs_stack_pop),
        .cs_stack_pointer(cs_stack_pointer), .cs_ret_pc(cs_ret_pc),
        .cs_ret_valid(cs_ret_valid), .cs_busy(cs_busy), .cs_full(cs_full),
        .cs_empty(cs_empty), .cs_overflow(cs_overflow), .cs_underflow(cs_underflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model is a list of return addresses plus a script of the cycles that an
    // accepted request still owes: one push cycle for a call, or a setup cycle
    // followed by a pop cycle for a ret.
    typedef struct packed {
        logic          push;
        logic          pop;
        logic [PW-1:0] rpc;
    } owed_t;

    owed_t         owed[$];
    logic [PW-1:0] stk[$];
    logic          m_ov, m_un;

    task automatic model_reset();
        owed.delete();
        stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs present now.
    task automatic model_edge();
        owed_t r;
        logic  ov_hit, un_hit;
        ov_hit = 1'b0;
        un_hit = 1'b0;
        if (owed.size() > 0) begin
            r = owed.pop_front();
            if (r.pop) void'(stk.pop_back());
        end else if (cs_call) begin
            if (stk.size() < DEPTH) begin
                stk.push_back(cs_pc_in + PW'(1));
                owed.push_back('{push: 1'b1, pop: 1'b0, rpc: '0});
            end else begin
                ov_hit = 1'b1;
            end
        end else if (cs_ret) begin
            if (stk.size() > 0) begin
                owed.push_back('{push: 1'b0, pop: 1'b0, rpc: '0});
                owed.push_back('{push: 1'b0, pop: 1'b1, rpc: stk[$]});
            end else begin
                un_hit = 1'b1;
            end
        end
        if (ov_hit) m_ov = 1'b1; else if (cs_flag_clr) m_ov = 1'b0;
        if (un_hit) m_un = 1'b1; else if (cs_flag_clr) m_un = 1'b0;
    endtask

    task automatic check_model(input string tag);
        owed_t e;
        e = (owed.size() > 0) ? owed[0] : owed_t'('0);
        chk({tag, ".push"}, cs_stack_push, e.push);
        chk({tag, ".pop"}, cs_stack_pop, e.pop);
        chk({tag, ".rv"}, cs_ret_valid, e.pop);
        chk({tag, ".rpc"}, cs_ret_pc, e.rpc);
        chk({tag, ".busy"}, cs_busy, owed.size() > 0);
        chk({tag, ".sp"}, cs_stack_pointer, stk.size());
        chk({tag, ".full"}, cs_full, stk.size() == DEPTH);
        chk({tag, ".empty"}, cs_empty, stk.size() == 0);
        chk({tag, ".ov"}, cs_overflow, m_ov);
        chk({tag, ".un"}, cs_underflow, m_un);
        chk({tag, ".push_pop_excl"}, cs_stack_push & cs_stack_pop, 1'b0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic c, input logic r, input logic [PW-1:0] pc, input logic clr);
        cs_call     = c;
        cs_ret      = r;
        cs_pc_in    = pc;
        cs_flag_clr = clr;
    endtask

    // One clock: update the model, then sample 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".push"}, cs_stack_push, 1'b0);
        chk({tag, ".pop"}, cs_stack_pop, 1'b0);
        chk({tag, ".rv"}, cs_ret_valid, 1'b0);
        chk({tag, ".busy"}, cs_busy, 1'b0);
        chk({tag, ".sp"}, cs_stack_pointer, 0);
        chk({tag, ".empty"}, cs_empty, 1'b1);
        chk({tag, ".full"}, cs_full, 1'b0);
        chk({tag, ".rpc"}, cs_ret_pc, 0);
        chk({tag, ".ov"}, cs_overflow, 1'b0);
        chk({tag, ".un"}, cs_underflow, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          call, ret, clr;
        logic [PW-1:0] pc;
        logic          push, pop, busy, ov, un;
        logic [PW-1:0] rpc;
        int            sp;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic c, input logic r, input logic clr, input logic [PW-1:0] pc,
                           input logic push, input logic pop, input logic busy,
                           input logic ov, input logic un, input logic [PW-1:0] rpc, input int sp);
        vec_t v;
        v.call = c;  v.ret = r;  v.clr = clr;  v.pc = pc;
        v.push = push;  v.pop = pop;  v.busy = busy;
        v.ov = ov;  v.un = un;  v.rpc = rpc;  v.sp = sp;
        vt.push_back(v);
    endtask

    initial begin
        string tag;
        // Columns: call ret clr pc | push pop busy ov un rpc sp
        add_vec(1, 0, 0, 5'h04, 1, 0, 1, 0, 0, 5'h00, 1); // call from PC 4, first edge after reset
        add_vec(0, 0, 0, 5'h00, 0, 0, 0, 0, 0, 5'h00, 1); // back to idle
        add_vec(0, 1, 0, 5'h00, 0, 0, 1, 0, 0, 5'h00, 1); // ret -> setup
        add_vec(0, 1, 0, 5'h00, 0, 1, 1, 0, 0, 5'h05, 1); // pop, ret held high while busy is ignored
        add_vec(0, 0, 0, 5'h00, 0, 0, 0, 0, 0, 5'h00, 0); // SP decremented
        add_vec(0, 1, 0, 5'h00, 0, 0, 0, 0, 1, 5'h00, 0); // ret on empty stack -> underflow
        add_vec(0, 0, 1, 5'h00, 0, 0, 0, 0, 0, 5'h00, 0); // clear
        add_vec(1, 1, 0, 5'h1F, 1, 0, 1, 0, 0, 5'h00, 1); // call+ret: call wins, PC 0x1F
        add_vec(1, 0, 0, 5'h03, 0, 0, 0, 0, 0, 5'h00, 1); // call while busy ignored
        add_vec(0, 1, 0, 5'h00, 0, 0, 1, 0, 0, 5'h00, 1); // ret -> setup
        add_vec(0, 0, 0, 5'h00, 0, 1, 1, 0, 0, 5'h00, 1); // pop, wrapped address 0
        add_vec(0, 0, 0, 5'h00, 0, 0, 0, 0, 0, 5'h00, 0);
        add_vec(0, 1, 1, 5'h00, 0, 0, 0, 0, 1, 5'h00, 0); // set beats clear
        add_vec(0, 0, 1, 5'h00, 0, 0, 0, 0, 0, 5'h00, 0); // clear

        // Reset is asserted; outputs must already be at their reset values.
        model_reset();
        #2;
        check_reset_values("reset");
        #10;
        rst_n = 1'b1;  // released at t=12, the next rising edge is at t=15

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].call, vt[i].ret, vt[i].pc, vt[i].clr);
            step();
            tag = $sformatf("vec%0d", i);
            chk({tag, ".push"}, cs_stack_push, vt[i].push);
            chk({tag, ".pop"}, cs_stack_pop, vt[i].pop);
            chk({tag, ".rv"}, cs_ret_valid, vt[i].pop);
            chk({tag, ".busy"}, cs_busy, vt[i].busy);
            chk({tag, ".rpc"}, cs_ret_pc, vt[i].rpc);
            chk({tag, ".sp"}, cs_stack_pointer, vt[i].sp);
            chk({tag, ".empty"}, cs_empty, vt[i].sp == 0);
            chk({tag, ".ov"}, cs_overflow, vt[i].ov);
            chk({tag, ".un"}, cs_underflow, vt[i].un);
        end

        // Fill to DEPTH, overflow once, then unwind in LIFO order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, PW'(i), 0);
            step();
            check_model($sformatf("fill%0d", i));
            drive(0, 0, '0, 0);
            step();
        end
        chk("full.flag", cs_full, 1'b1);
        chk("full.sp", cs_stack_pointer, DEPTH);
        drive(1, 0, 5'h10, 0);
        step();
        chk("ovf.push", cs_stack_push, 1'b0);
        chk("ovf.flag", cs_overflow, 1'b1);
        chk("ovf.sp", cs_stack_pointer, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, '0, 0);
            step();
            drive(0, 0, '0, 0);
            step();
            chk($sformatf("lifo%0d.rpc", i), cs_ret_pc, DEPTH - i);
            check_model($sformatf("lifo%0d", i));
            step();
        end
        drive(0, 0, '0, 1);
        step();
        check_model("clr_ov");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  PW'($urandom), $urandom_range(0, 9) == 0);
            step();
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset during RET_SETUP.
        drive(0, 0, '0, 1);
        step();
        while (owed.size() > 0) step();
        drive(1, 0, 5'h09, 0);
        step();
        drive(0, 0, '0, 0);
        step();
        drive(0, 1, '0, 0);
        step();
        chk("rst_mid.in_setup", cs_busy & ~cs_stack_pop, 1'b1);
        drive(0, 0, '0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_async");
        @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        rst_n = 1'b1;

        // The first request after release is taken on the first edge.
        drive(1, 0, 5'h0A, 0);
        step();
        check_model("post_rst_call");
        drive(0, 0, '0, 0);
        step();
        check_model("post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish before 200000");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
